// File: rtl/control_plane_feeder.sv
`default_nettype none
// ============================================================================
// Module      : control_plane_feeder
// Description : Accepts a table-load packet (header + payload phits) from a
//               valid/ready stream, buffers it whole, then replays it on the
//               control_plane load port: start_loader pulse, fixed gap, one
//               phit per cycle, then a stream-in handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module control_plane_feeder #(
  parameter int phit_size    = 512,
  parameter int dwidth_RFadd = 8,
  parameter int NUM_STAGE    = 6,
  parameter int FIFO_DEPTH   = 64,
  parameter int LOAD_GAP     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [phit_size-1:0]    s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    start_loader,
  output logic [phit_size-1:0]    wr_data,
  output logic [dwidth_RFadd-1:0] num_entry_config_table,
  output logic [dwidth_RFadd-1:0] num_entry_inbound,
  output logic                    start_stream_in,
  input  logic                    ready_stream_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] GAP_LAST = 16'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, FILL, DRAIN, START, GAP, SEND, STREAM, DONE, ERR
  } state_t;

  state_t                  state, next_state;
  logic [15:0]             cnt, cnt_next;
  logic [15:0]             total;
  logic [15:0]             hdr_total;
  logic [dwidth_RFadd-1:0] cfg_lat, inb_lat;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [phit_size-1:0]    mem [FIFO_DEPTH];
  logic                    xfer;
  logic                    hdr_accept;
  logic                    pop;

  assign xfer       = s_valid & s_ready;
  assign hdr_accept = (state == IDLE) && xfer;
  assign pop        = (next_state == SEND);
  assign hdr_total  = 16'(s_data[7:0])
                    + 16'(NUM_STAGE) * 16'(s_data[dwidth_RFadd+15:16])
                    + 16'(s_data[dwidth_RFadd+31:32]);

  // Next-state and shared cycle/phit counter.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (xfer) begin
          if (hdr_total == 16'd0)                   next_state = ERR;
          else if (hdr_total > 16'(FIFO_DEPTH))     next_state = DRAIN;
          else                                      next_state = FILL;
        end
      end
      FILL, DRAIN: begin
        if (xfer) begin
          if (cnt == total - 16'd1) begin
            next_state = (state == FILL) ? START : ERR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 16'd1;
          end
        end
      end
      START: begin
        cnt_next   = '0;
        next_state = (LOAD_GAP == 0) ? SEND : GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          next_state = SEND;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      SEND: begin
        if (cnt == total - 16'd1) begin
          next_state = STREAM;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      STREAM: if (ready_stream_in) next_state = DONE;
      DONE:   next_state = IDLE;
      ERR:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, counter and registered control outputs; reset forces every output low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      s_ready         <= 1'b0;
      start_loader    <= 1'b0;
      start_stream_in <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= next_state;
      cnt             <= cnt_next;
      s_ready         <= (next_state == IDLE) || (next_state == FILL) || (next_state == DRAIN);
      start_loader    <= (next_state == START);
      start_stream_in <= (next_state == STREAM);
      busy            <= (next_state != IDLE);
      done            <= (next_state == DONE);
      err             <= (next_state == ERR);
    end
  end

  // Header latch; entry counts are published from START until the next header.
  always_ff @(posedge clk) begin
    if (!rst) begin
      total                  <= '0;
      cfg_lat                <= '0;
      inb_lat                <= '0;
      num_entry_config_table <= '0;
      num_entry_inbound      <= '0;
    end else begin
      if (hdr_accept) begin
        total                  <= hdr_total;
        cfg_lat                <= s_data[dwidth_RFadd+15:16];
        inb_lat                <= s_data[dwidth_RFadd+31:32];
        num_entry_config_table <= '0;
        num_entry_inbound      <= '0;
      end else if (next_state == START) begin
        num_entry_config_table <= cfg_lat;
        num_entry_inbound      <= inb_lat;
      end
    end
  end

  // FIFO pointers; fill completes before replay so they never move together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (state == FILL && xfer) wr_ptr <= wr_ptr + AW'(1);
      if (pop)                   rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (state == FILL && xfer) mem[wr_ptr] <= s_data;
  end

  // Registered load phit: popped the cycle before it is shown, zero otherwise.
  always_ff @(posedge clk) begin
    if (!rst) wr_data <= '0;
    else      wr_data <= pop ? mem[rd_ptr] : '0;
  end

endmodule
`default_nettype wire
